// File: rtl/aom_para_sched.sv
// AOM parameter scheduler: laser start/stop sequencing and
// shadow-to-live parameter commits gated on quiet trim flags.
module aom_para_sched #(
   parameter int ARM_CYC     = 16,
   parameter int QUIET_CYC   = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        scan_start_i,
   input  logic        scan_stop_i,
   input  logic        cfg_vld_i,
   output logic        cfg_rdy_o,
   input  logic [2:0]  cfg_addr_i,
   input  logic [31:0] cfg_data_i,
   input  logic        commit_i,
   input  logic        aom_ctrl_flag_i,
   input  logic        lp_recover_flag_i,
   input  logic        recover_edge_flag_i,
   output logic        laser_start_o,
   output logic [31:0] light_spot_para_o,
   output logic signed [15:0] aom_ctrl_delay_o,
   output logic [15:0] aom_ctrl_hold_o,
   output logic signed [15:0] lp_recover_delay_o,
   output logic [15:0] lp_recover_hold_o,
   output logic [15:0] recover_edge_slot_time_o,
   output logic        commit_pend_o,
   output logic        commit_done_o,
   output logic        timeout_o,
   output logic [2:0]  state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_RUN    = 3'd2,
      S_UPDATE = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   localparam logic [16:0] CMAX     = 17'h1FFFF;
   localparam logic [16:0] ARM_LAST = 17'(ARM_CYC - 1);
   localparam logic [16:0] TO_LAST  = 17'(TIMEOUT_CYC - 1);
   localparam logic [16:0] Q_FULL   = 17'(QUIET_CYC);

   state_t      state_q, state_d;
   logic [16:0] cnt_q, cnt_d, cnt_inc;
   logic [16:0] qcnt_q, qcnt_d;
   logic        pend_q;
   logic        do_copy, tmo, laser, quiet, quiet_full, wr_en;

   logic [31:0] sh_spot;
   logic [15:0] sh_adly, sh_ahld, sh_rdly, sh_rhld, sh_slot;

   assign quiet      = ~(aom_ctrl_flag_i | lp_recover_flag_i |
                         recover_edge_flag_i);
   assign quiet_full = (qcnt_q == Q_FULL);
   assign cnt_inc    = (cnt_q == CMAX) ? cnt_q : cnt_q + 17'd1;
   assign cfg_rdy_o  = ~rst_i & (state_q != S_UPDATE);
   assign wr_en      = cfg_vld_i & cfg_rdy_o;

   // Next state, wait counter and copy/timeout strobes
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      do_copy = 1'b0;
      tmo     = 1'b0;
      laser   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d   = '0;
            do_copy = pend_q;
            if (scan_start_i && !scan_stop_i) state_d = S_ARM;
         end
         S_ARM: begin
            do_copy = pend_q;
            cnt_d   = cnt_inc;
            if (scan_stop_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q >= ARM_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            laser = 1'b1;
            cnt_d = '0;
            if (scan_stop_i) begin
               state_d = S_DRAIN;
            end else if (pend_q) begin
               if (quiet_full) begin
                  state_d = S_UPDATE;
               end else if (cnt_q >= TO_LAST) begin
                  state_d = S_UPDATE;
                  tmo     = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_UPDATE: begin
            laser   = 1'b1;
            do_copy = pend_q;
            cnt_d   = '0;
            state_d = scan_stop_i ? S_DRAIN : S_RUN;
         end
         S_DRAIN: begin
            laser = 1'b1;
            cnt_d = '0;
            if (quiet_full) begin
               state_d = S_IDLE;
            end else if (cnt_q >= TO_LAST) begin
               state_d = S_IDLE;
               tmo     = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Saturating count of consecutive quiet cycles
   always_comb begin
      qcnt_d = '0;
      if (quiet) qcnt_d = quiet_full ? qcnt_q : qcnt_q + 17'd1;
   end

   // State, counters and pending commit flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         qcnt_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         qcnt_q  <= qcnt_d;
         pend_q  <= (pend_q & ~do_copy) | commit_i;
      end
   end

   // Shadow register writes; reserved addresses are dropped
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sh_spot <= '0;
         sh_adly <= '0;
         sh_ahld <= '0;
         sh_rdly <= '0;
         sh_rhld <= '0;
         sh_slot <= '0;
      end else if (wr_en) begin
         case (cfg_addr_i)
            3'd0:    sh_spot <= cfg_data_i;
            3'd1:    sh_adly <= cfg_data_i[15:0];
            3'd2:    sh_ahld <= cfg_data_i[15:0];
            3'd3:    sh_rdly <= cfg_data_i[15:0];
            3'd4:    sh_rhld <= cfg_data_i[15:0];
            3'd5:    sh_slot <= cfg_data_i[15:0];
            default: ;
         endcase
      end
   end

   // Live parameters move together on the copy cycle only
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         light_spot_para_o        <= '0;
         aom_ctrl_delay_o         <= '0;
         aom_ctrl_hold_o          <= '0;
         lp_recover_delay_o       <= '0;
         lp_recover_hold_o        <= '0;
         recover_edge_slot_time_o <= '0;
      end else if (do_copy) begin
         light_spot_para_o        <= sh_spot;
         aom_ctrl_delay_o         <= sh_adly;
         aom_ctrl_hold_o          <= sh_ahld;
         lp_recover_delay_o       <= sh_rdly;
         lp_recover_hold_o        <= sh_rhld;
         recover_edge_slot_time_o <= sh_slot;
      end
   end

   assign laser_start_o = laser;
   assign commit_pend_o = pend_q;
   assign commit_done_o = do_copy;
   assign timeout_o     = tmo;
   assign state_o       = state_q;

endmodule

// File: tb/tb_aom_para_sched.sv
// Directed bench for aom_para_sched with a shortened timeout.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_aom_para_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop, vld, commit;
   logic [2:0]  addr;
   logic [31:0] data;
   logic        f_aom, f_lp, f_edge;
   logic        rdy, laser, pend, done, tmo;
   logic [31:0] spot;
   logic [15:0] adly, ahld, rdly, rhld, slot;
   logic [2:0]  st;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aom_para_sched #(
      .ARM_CYC(16),
      .QUIET_CYC(4),
      .TIMEOUT_CYC(20)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .scan_start_i(start),
      .scan_stop_i(stop),
      .cfg_vld_i(vld),
      .cfg_rdy_o(rdy),
      .cfg_addr_i(addr),
      .cfg_data_i(data),
      .commit_i(commit),
      .aom_ctrl_flag_i(f_aom),
      .lp_recover_flag_i(f_lp),
      .recover_edge_flag_i(f_edge),
      .laser_start_o(laser),
      .light_spot_para_o(spot),
      .aom_ctrl_delay_o(adly),
      .aom_ctrl_hold_o(ahld),
      .lp_recover_delay_o(rdly),
      .lp_recover_hold_o(rhld),
      .recover_edge_slot_time_o(slot),
      .commit_pend_o(pend),
      .commit_done_o(done),
      .timeout_o(tmo),
      .state_o(st)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      {start, stop, vld, commit, f_aom, f_lp, f_edge} = '0;
      addr = '0;
      data = '0;
      #1;
      chk("rst_rdy", 32'(rdy), 32'd0);
      step(2);
      rst = 1'b0;
      #1;
      chk("rst_state", 32'(st), 32'd0);
      chk("rst_laser", 32'(laser), 32'd0);
      chk("rst_pend", 32'(pend), 32'd0);
      chk("rst_spot", spot, 32'd0);
      chk("idle_rdy", 32'(rdy), 32'd1);

      // IDLE commit of two writes
      vld = 1'b1; addr = 3'd1; data = 32'h0000_FFF0;
      step(1);
      addr = 3'd2; data = 32'd100; commit = 1'b1;
      step(1);
      vld = 1'b0; commit = 1'b0;
      chk("idle_done", 32'(done), 32'd1);
      chk("idle_pend", 32'(pend), 32'd1);
      chk("idle_adly_old", 32'(adly), 32'd0);
      step(1);
      chk("idle_adly", 32'(adly), 32'h0000_FFF0);
      chk("idle_ahld", 32'(ahld), 32'd100);
      chk("idle_spot", spot, 32'd0);
      chk("idle_slot", 32'(slot), 32'd0);
      chk("idle_done_off", 32'(done), 32'd0);
      chk("idle_pend_clr", 32'(pend), 32'd0);

      // start and stop together in IDLE
      start = 1'b1; stop = 1'b1;
      step(1);
      start = 1'b0; stop = 1'b0;
      chk("ss_noop", 32'(st), 32'd0);

      // arm delay
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("arm_state", 32'(st), 32'd1);
      step(15);
      chk("arm_16_state", 32'(st), 32'd1);
      chk("arm_16_laser", 32'(laser), 32'd0);
      step(1);
      chk("run_state", 32'(st), 32'd2);
      chk("run_laser", 32'(laser), 32'd1);

      // commit held off by busy flag
      f_aom = 1'b1;
      step(5);
      commit = 1'b1; vld = 1'b1; addr = 3'd0; data = 32'hA5A5_0001;
      step(1);
      commit = 1'b0; vld = 1'b0;
      step(10);
      chk("busy_pend", 32'(pend), 32'd1);
      chk("busy_state", 32'(st), 32'd2);
      chk("busy_spot", spot, 32'd0);
      f_aom = 1'b0;
      step(4);
      chk("quiet4_state", 32'(st), 32'd2);
      chk("quiet4_spot", spot, 32'd0);
      step(1);
      chk("upd_state", 32'(st), 32'd3);
      chk("upd_done", 32'(done), 32'd1);
      chk("upd_rdy", 32'(rdy), 32'd0);
      chk("upd_tmo", 32'(tmo), 32'd0);
      vld = 1'b1; addr = 3'd5; data = 32'h0000_0055;
      step(1);
      vld = 1'b0;
      chk("post_upd_state", 32'(st), 32'd2);
      chk("post_upd_spot", spot, 32'hA5A5_0001);
      chk("post_upd_ahld", 32'(ahld), 32'd100);

      // forced commit after timeout
      f_aom = 1'b1;
      commit = 1'b1; vld = 1'b1; addr = 3'd4; data = 32'h0000_0BEE;
      step(1);
      commit = 1'b0; vld = 1'b0;
      step(18);
      chk("to18_state", 32'(st), 32'd2);
      chk("to18_tmo", 32'(tmo), 32'd0);
      step(1);
      chk("to_tmo", 32'(tmo), 32'd1);
      chk("to_state", 32'(st), 32'd2);
      step(1);
      chk("to_upd", 32'(st), 32'd3);
      chk("to_upd_tmo", 32'(tmo), 32'd0);
      step(1);
      chk("to_rhld", 32'(rhld), 32'h0000_0BEE);
      chk("to_slot_drop", 32'(slot), 32'd0);
      chk("to_run", 32'(st), 32'd2);

      // forced drain exit after timeout
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      chk("drn_state", 32'(st), 32'd4);
      step(19);
      chk("drn_to_laser", 32'(laser), 32'd1);
      chk("drn_to_tmo", 32'(tmo), 32'd1);
      step(1);
      chk("drn_to_idle", 32'(st), 32'd0);
      chk("drn_to_laser0", 32'(laser), 32'd0);
      f_aom = 1'b0;

      // quiet drain exit
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(16);
      chk("run2_state", 32'(st), 32'd2);
      f_lp = 1'b1; stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(9);
      chk("drn2_busy", 32'(st), 32'd4);
      f_lp = 1'b0;
      step(4);
      chk("drn2_q_laser", 32'(laser), 32'd1);
      chk("drn2_q_tmo", 32'(tmo), 32'd0);
      step(1);
      chk("drn2_idle", 32'(st), 32'd0);
      chk("drn2_laser0", 32'(laser), 32'd0);

      // reset mid-ARM with commit pending
      start = 1'b1;
      step(1);
      start = 1'b0;
      commit = 1'b1; vld = 1'b1; addr = 3'd0; data = 32'hDEAD_BEEF;
      step(1);
      commit = 1'b0; vld = 1'b0;
      chk("arm_pend", 32'(pend), 32'd1);
      chk("arm_done", 32'(done), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_state", 32'(st), 32'd0);
      chk("arst_pend", 32'(pend), 32'd0);
      chk("arst_spot", spot, 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_ahld", 32'(ahld), 32'd0);
      step(1);
      rst = 1'b0;
      step(2);
      chk("arst_spot2", spot, 32'd0);
      chk("arst_state2", 32'(st), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
